// File: rtl/cv32e40p_mult_fault_mgr.sv
// Fault manager for the TMR multiplier: accumulates voter mismatches per op,
// requests replays of faulty ops and escalates repeated faults to an alert.
module cv32e40p_mult_fault_mgr #(
    parameter int CNT_W       = 16,
    parameter int PERM_THRESH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mult_enable_i,
    input  logic             mult_ready_i,
    input  logic             ex_ready_i,
    input  logic             result_fault_i,
    input  logic             multicycle_fault_i,
    input  logic             mulh_fault_i,
    input  logic             ready_fault_i,
    input  logic             alert_ack_i,
    input  logic             clear_i,
    output logic             retry_o,
    output logic             alert_o,
    output logic             degraded_o,
    output logic [CNT_W-1:0] fault_cnt_o,
    output logic [3:0]       consec_cnt_o,
    output logic [3:0]       sticky_o
);

    typedef enum logic [1:0] {OK, RETRY, PERM, PERM_ACKED} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [3:0]       THRESH  = 4'(PERM_THRESH);

    state_t           state_q, state_d;
    logic [3:0]       op_mask_q, op_mask_d;
    logic [CNT_W-1:0] fault_cnt_q, fault_cnt_d;
    logic [3:0]       consec_q, consec_d;
    logic [3:0]       sticky_q, sticky_d;
    logic [3:0]       fault_vec;
    logic [3:0]       acc;
    logic             complete;
    logic             faulty;

    assign fault_vec = mult_enable_i ?
        {ready_fault_i, mulh_fault_i, multicycle_fault_i, result_fault_i} : 4'b0;
    assign acc       = op_mask_q | fault_vec;
    assign complete  = mult_enable_i & mult_ready_i & ex_ready_i;
    assign faulty    = complete & (|acc);

    always_comb begin
        state_d     = state_q;
        fault_cnt_d = fault_cnt_q;
        consec_d    = consec_q;
        sticky_d    = sticky_q;
        // Mask survives only while the op is still running.
        op_mask_d   = (mult_enable_i && !complete) ? acc : 4'b0;

        if (faulty) begin
            if (fault_cnt_q != CNT_MAX)
                fault_cnt_d = fault_cnt_q + CNT_W'(1);
            if (consec_q != 4'hf)
                consec_d = consec_q + 4'd1;
            sticky_d = sticky_q | acc;
        end else if (complete) begin
            consec_d = 4'd0;
        end

        case (state_q)
            OK, RETRY: begin
                if (faulty)
                    state_d = (consec_d >= THRESH) ? PERM : RETRY;
                else
                    state_d = OK;
            end
            PERM: begin
                if (alert_ack_i)
                    state_d = PERM_ACKED;
            end
            PERM_ACKED: state_d = PERM_ACKED;
            default:    state_d = OK;
        endcase

        // Clear drops any coincident completion.
        if (clear_i) begin
            state_d     = OK;
            fault_cnt_d = '0;
            consec_d    = 4'd0;
            sticky_d    = 4'd0;
            op_mask_d   = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= OK;
            op_mask_q   <= 4'd0;
            fault_cnt_q <= '0;
            consec_q    <= 4'd0;
            sticky_q    <= 4'd0;
        end else begin
            state_q     <= state_d;
            op_mask_q   <= op_mask_d;
            fault_cnt_q <= fault_cnt_d;
            consec_q    <= consec_d;
            sticky_q    <= sticky_d;
        end
    end

    assign retry_o      = (state_q == RETRY);
    assign alert_o      = (state_q == PERM);
    assign degraded_o   = (state_q == PERM) || (state_q == PERM_ACKED);
    assign fault_cnt_o  = fault_cnt_q;
    assign consec_cnt_o = consec_q;
    assign sticky_o     = sticky_q;

endmodule

// File: tb/tb_cv32e40p_mult_fault_mgr.sv
// Bench for cv32e40p_mult_fault_mgr: directed scenarios plus random traffic
// checked every cycle against a behavioural model.
module tb_cv32e40p_mult_fault_mgr;

    localparam int CNT_W = 4;
    localparam int THR   = 3;

    logic clk = 1'b0;
    logic rst, en, rdy, exr, ack, clr;
    logic [3:0] fv;
    logic retry, alert, degraded;
    logic [CNT_W-1:0] fcnt;
    logic [3:0] consec, sticky;

    int checks = 0;
    int passed = 0;

    // behavioural model
    int  m_fcnt, m_consec, m_sticky, m_mask;
    bit  m_perm, m_alert, m_retry;

    always #5 clk = ~clk;

    cv32e40p_mult_fault_mgr #(.CNT_W(CNT_W), .PERM_THRESH(THR)) dut (
        .clk(clk), .rst(rst),
        .mult_enable_i(en), .mult_ready_i(rdy), .ex_ready_i(exr),
        .result_fault_i(fv[0]), .multicycle_fault_i(fv[1]),
        .mulh_fault_i(fv[2]), .ready_fault_i(fv[3]),
        .alert_ack_i(ack), .clear_i(clr),
        .retry_o(retry), .alert_o(alert), .degraded_o(degraded),
        .fault_cnt_o(fcnt), .consec_cnt_o(consec), .sticky_o(sticky)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_step();
        int acc;
        bit comp;
        if (rst || clr) begin
            m_fcnt = 0; m_consec = 0; m_sticky = 0; m_mask = 0;
            m_perm = 0; m_alert = 0; m_retry = 0;
            return;
        end
        comp = en && rdy && exr;
        acc = m_mask | (en ? int'(fv) : 0);
        m_retry = 0;
        if (m_alert && ack) m_alert = 0;
        if (comp && acc != 0) begin
            m_fcnt   = (m_fcnt < 15) ? m_fcnt + 1 : 15;
            m_consec = (m_consec < 15) ? m_consec + 1 : 15;
            m_sticky = m_sticky | acc;
            if (!m_perm) begin
                if (m_consec >= THR) begin
                    m_perm = 1; m_alert = 1;
                end else begin
                    m_retry = 1;
                end
            end
        end else if (comp) begin
            m_consec = 0;
        end
        m_mask = (en && !comp) ? acc : 0;
    endtask

    task automatic compare_all();
        check("retry", int'(retry), int'(m_retry));
        check("alert", int'(alert), int'(m_alert));
        check("degraded", int'(degraded), int'(m_perm));
        check("fault_cnt", int'(fcnt), m_fcnt);
        check("consec", int'(consec), m_consec);
        check("sticky", int'(sticky), m_sticky);
    endtask

    task automatic cyc(input logic e, input logic r, input logic x,
                       input logic [3:0] f, input logic a,
                       input logic c, input logic rs);
        en = e; rdy = r; exr = x; fv = f; ack = a; clr = c; rst = rs;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 4'b0, 0, 0, 1);
    endtask

    task automatic faulty_op();
        cyc(1, 1, 1, 4'b0001, 0, 0, 0);
    endtask

    task automatic clean_op();
        cyc(1, 1, 1, 4'b0000, 0, 0, 0);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 4'b0, 0, 0, 0);
    endtask

    initial begin
        en = 0; rdy = 0; exr = 0; fv = 0; ack = 0; clr = 0; rst = 1;
        m_fcnt = 0; m_consec = 0; m_sticky = 0; m_mask = 0;
        m_perm = 0; m_alert = 0; m_retry = 0;
        @(posedge clk);
        do_reset();
        check("reset_cnt", int'(fcnt), 0);
        check("reset_degraded", int'(degraded), 0);

        // single-cycle faulty op
        faulty_op();
        check("sc_retry", int'(retry), 1);
        check("sc_sticky", int'(sticky), 1);
        idle();
        check("sc_retry_pulse", int'(retry), 0);

        // 3-cycle op, fault only in first cycle
        do_reset();
        cyc(1, 0, 1, 4'b0100, 0, 0, 0);
        cyc(1, 0, 1, 4'b0000, 0, 0, 0);
        cyc(1, 1, 1, 4'b0000, 0, 0, 0);
        check("mc_cnt", int'(fcnt), 1);
        check("mc_sticky", int'(sticky), 4);
        check("mc_retry", int'(retry), 1);

        // abandoned op is not counted
        do_reset();
        cyc(1, 0, 1, 4'b1000, 0, 0, 0);
        idle();
        clean_op();
        check("abandon_cnt", int'(fcnt), 0);

        // escalation to PERM, then acknowledge
        do_reset();
        faulty_op(); check("p1_retry", int'(retry), 1); idle();
        faulty_op(); check("p2_retry", int'(retry), 1); idle();
        faulty_op();
        check("p3_alert", int'(alert), 1);
        check("p3_retry", int'(retry), 0);
        cyc(0, 0, 0, 4'b0, 1, 0, 0);
        check("ack_alert", int'(alert), 0);
        check("ack_degraded", int'(degraded), 1);
        cyc(0, 0, 0, 4'b0, 1, 0, 0);

        // clear beats faulty completion in PERM_ACKED
        cyc(1, 1, 1, 4'b0011, 0, 1, 0);
        check("clr_degraded", int'(degraded), 0);
        check("clr_cnt", int'(fcnt), 0);
        check("clr_retry", int'(retry), 0);

        // faulty, clean, faulty
        faulty_op(); check("fcf_c1", int'(consec), 1);
        clean_op();  check("fcf_c0", int'(consec), 0);
        faulty_op(); check("fcf_c2", int'(consec), 1);
        check("fcf_cnt", int'(fcnt), 2);

        // total counter saturation
        do_reset();
        for (int i = 0; i < 20; i++) begin
            faulty_op();
            clean_op();
        end
        check("sat_cnt", int'(fcnt), 15);
        check("sat_degraded", int'(degraded), 0);

        // reset in PERM
        faulty_op(); faulty_op(); faulty_op();
        check("pre_rst_alert", int'(alert), 1);
        do_reset();
        check("rst_alert", int'(alert), 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] f;
            f = {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0)};
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4,
                $urandom_range(0, 9) < 8, f,
                $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0,
                $urandom_range(0, 199) == 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/cv32e40p_mult_fault_mgr.md
CV32E40P_MULT_FAULT_MGR -- requirements
Module: cv32e40p_mult_fault_mgr

Interface
REQ-001 Parameters: CNT_W, default 16, width of total fault counter; PERM_THRESH, default 3, consecutive faulty ops that declare a permanent fault (range 1..15).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 mult_enable_i  in  1  multiplier operation in progress (same signal driving the TMR multiplier enable).
REQ-005 mult_ready_i  in  1  voted multiplier ready.
REQ-006 ex_ready_i  in  1  EX stage accepts result.
REQ-007 result_fault_i, multicycle_fault_i, mulh_fault_i, ready_fault_i  in  1 each  voter mismatch flags.
REQ-008 alert_ack_i  in  1  software/controller acknowledge of alert.
REQ-009 clear_i  in  1  clears all counters, sticky mask and state.
REQ-010 retry_o  out  1  one-cycle request to replay the just-completed multiply.
REQ-011 alert_o  out  1  permanent-fault alert, level, held until acknowledged.
REQ-012 degraded_o  out  1  multiplier declared permanently faulty.
REQ-013 fault_cnt_o  out  CNT_W  total faulty operations, saturating.
REQ-014 consec_cnt_o  out  4  consecutive faulty operations.
REQ-015 sticky_o  out  4  sticky mask {ready, mulh, multicycle, result}.

Function
REQ-016 fault_vec = {ready_fault_i, mulh_fault_i, multicycle_fault_i, result_fault_i}; a fault is sampled only in cycles with mult_enable_i=1.
REQ-017 op_mask register SHALL OR-accumulate fault_vec over every enabled cycle of an operation, including the completion cycle.
REQ-018 Completion event = mult_enable_i & mult_ready_i & ex_ready_i; op_mask SHALL clear to 0 the cycle after completion.
REQ-019 Faulty completion (op_mask|fault_vec != 0): fault_cnt_o +1 saturating at 2^CNT_W-1; consec_cnt_o +1 saturating at 15; sticky_o |= accumulated mask.
REQ-020 Clean completion: consec_cnt_o SHALL return to 0; fault_cnt_o and sticky_o unchanged.
REQ-021 FSM states OK, RETRY, PERM, PERM_ACKED.
REQ-022 OK: faulty completion with new consec < PERM_THRESH -> RETRY; with new consec >= PERM_THRESH -> PERM.
REQ-023 RETRY: lasts exactly one cycle, retry_o=1, then -> OK; completion in this cycle handled as in OK.
REQ-024 PERM: alert_o=1, degraded_o=1; alert_ack_i -> PERM_ACKED next cycle.
REQ-025 PERM_ACKED: alert_o=0, degraded_o=1; counters keep updating; only clear_i or rst leaves.
REQ-026 retry_o SHALL never assert in PERM or PERM_ACKED; alert_o only in PERM.
REQ-027 clear_i: next cycle state OK, all counters, sticky_o, op_mask = 0; clear_i wins over a simultaneous completion (event dropped).
REQ-028 alert_ack_i outside PERM SHALL be ignored.
REQ-029 Outputs registered; response latency one cycle after the completion event.
REQ-030 mult_enable_i deasserted mid-operation without completion: op_mask SHALL clear (op abandoned, not counted).

Reset
REQ-031 rst=1 at a rising edge: state OK, retry_o=0, alert_o=0, degraded_o=0, fault_cnt_o=0, consec_cnt_o=0, sticky_o=0, op_mask=0.
REQ-032 Reset mid-operation or in PERM SHALL discard the in-flight op and alert with no retry pulse.

Verification
REQ-033 Single-cycle op, result_fault_i=1 at completion -> next cycle retry_o=1 for 1 cycle, fault_cnt=1, consec=1, sticky=4'b0001.
REQ-034 3-cycle op, mulh_fault_i=1 only in cycle 1, clean at completion -> counted: fault_cnt=1, sticky=4'b0100, retry_o pulse.
REQ-035 PERM_THRESH=3, three consecutive faulty ops -> retry after ops 1,2; after op 3 alert_o=1, degraded_o=1, no retry; alert_ack_i -> alert_o=0, degraded_o stays 1.
REQ-036 Faulty, clean, faulty sequence -> consec goes 1,0,1; fault_cnt=2; never PERM.
REQ-037 CNT_W=4, 20 faulty ops with clears of consec via interleaved clean ops -> fault_cnt_o saturates at 15.
REQ-038 clear_i coincident with faulty completion in PERM_ACKED -> next cycle state OK, all counters 0, no retry_o.
